phy_rx_link_ctrl: RTL and testbench
===================================

# phy_rx_link_ctrl

Receive-side link controller for the two-lane PHY receiver. It watches the parallel bytes from both serial-to-parallel lanes, acquires and tracks per-lane symbol lock on the 0xBC comma/idle character, and brings the link up once both lanes are locked and aligned. It then drives the enable that lets the byte-unstripping and demux path accept data. It sits between the two serialtopar lanes and byte_unstripping in the `clk_f` domain.

## Interface
- `LOCK_CNT`, 4: consecutive comma bytes required to declare lane lock.
- `LOSS_CNT`, 3: consecutive bad bytes in LOCKED that drop lane lock.
- `ALIGN_TO`, 16: cycles allowed in ALIGN before giving up.
- `clk_f` input 1: sole clock, parallel byte rate. Everything is on the rising edge.
- `reset_L` input 1: synchronous, active-low reset, sampled on the rising edge of `clk_f`.
- `link_en` input 1: software enable. Low forces the link down.
- `data_par_0`, `data_par_1` input 8: parallel byte per lane.
- `valid_par_0`, `valid_par_1` input 1: lane byte is payload (1) or idle/control (0).
- `lane_lock_0`, `lane_lock_1` output 1: lane in LOCKED.
- `link_up` output 1: link FSM in UP.
- `unstrip_en` output 1: enable for byte_unstripping. Equals `link_up`, registered identically.
- `align_fail` output 4: saturating count of ALIGN timeouts.

## Operation
- Byte classes per lane, each cycle:
  - COM: `valid_par`=0 and `data_par`=0xBC.
  - DATA: `valid_par`=1.
  - BAD: `valid_par`=0 and `data_par`≠0xBC.
- Lane FSM, one per lane:
  - SEARCH: COM → ACQUIRE with `cnt`=1; otherwise stay.
  - ACQUIRE: COM → `cnt`+1, and entry to LOCKED when `cnt`+1 = `LOCK_CNT`. DATA or BAD → SEARCH with `cnt`=0.
  - LOCKED: COM or DATA → `bad`=0. BAD → `bad`+1, and entry to SEARCH when `bad`+1 = `LOSS_CNT`, with `bad` and `cnt` cleared.
- Link FSM:
  - DOWN: `link_en` and both lanes locked → ALIGN with `tmr`=0.
  - ALIGN: both lanes COM in the same cycle → UP. Otherwise `tmr`+1. On `tmr` = `ALIGN_TO`-1 → DOWN and `align_fail`+1, saturating at 15.
  - UP: stays while `link_en` and both locks hold.
- Exits to DOWN from ALIGN or UP: `link_en`=0, or either lane leaving LOCKED.
- Precedence for simultaneous events: lock loss or `link_en` low beats alignment success and timeout. A timeout coinciding with lock loss does not increment `align_fail`.
- `align_fail` is cleared only by reset.
- Counter widths: `cnt` is $clog2(`LOCK_CNT`+1), `bad` is $clog2(`LOSS_CNT`+1), `tmr` is $clog2(`ALIGN_TO`). None of them wraps.

## Timing
- Reset (`reset_L`=0 at an edge) puts both lane FSMs in SEARCH, the link FSM in DOWN, and all counters at 0.
- Every output is 0 in the cycle after a reset edge.
- Reset asserted mid-operation drops `link_up` and `unstrip_en` at that same edge.
- All outputs are registered state decodes with no combinational input-to-output path.
- `lane_lock_x` rises in the cycle after the edge that samples the `LOCK_CNT`-th consecutive COM.
- `lane_lock_x` falls in the cycle after the edge that samples the `LOSS_CNT`-th consecutive BAD.
- Minimum lock-to-UP latency:
  - Edge n: both locks register. The link FSM sees them and enters ALIGN at edge n+1.
  - Edge n+2 at the earliest: a common COM is sampled. `link_up` and `unstrip_en` are high from that edge.
- `link_up` falls at the edge after the lock-loss edge, so one cycle after `lane_lock_x` falls.

## Structure
- Shared package `phy_pkg`:
  - `COM_CHAR` = 8'hBC.
  - Lane state enum: SEARCH, ACQUIRE, LOCKED.
  - Link state enum: DOWN, ALIGN, UP.
- Sub-module `phy_rx_lane_sync`:
  - Ports: `clk_f`, `reset_L`, `data_par`, `valid_par`, `lane_lock`.
  - Holds the lane FSM plus the `cnt` and `bad` counters.
  - Instantiated twice.
- Top holds the link FSM, `tmr` and `align_fail`.

## Test plan
- Reset, then 4 COM bytes on both lanes with `link_en`=1 → both `lane_lock` high after the 4th COM; `link_up` high 2 cycles later.
- Lane 0 sends COM,COM,DATA(0x55),COM×4 → lock only after the final COM run; no lock after the first 2 COMs.
- Link UP, lane 1 sends BAD(0x00)×2 then COM → lock held and `bad` cleared; a later BAD×3 drops `lane_lock_1` and then `link_up`.
- Both lanes locked, lane 1 shifted so COM never coincides for 16 cycles → back to DOWN with `align_fail`=1; 16 repeats saturate it at 15.
- Link UP, `link_en` driven 0 → `link_up` and `unstrip_en` low next cycle while lane locks stay high; `link_en` back to 1 → re-enter ALIGN.
- `reset_L` pulsed low while UP → all outputs 0 the next cycle; full reacquisition required.

Source files
------------

// File: rtl/phy_rx_link_ctrl_pkg.sv
// Shared definitions for the two-lane PHY receive link controller:
// the comma character, the lane/link state encodings and the comma classifier.
package phy_pkg;

    localparam logic [7:0] COM_CHAR = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } lane_state_e;

    typedef enum logic [1:0] {
        DOWN,
        ALIGN,
        UP
    } link_state_e;

    // A comma is an idle/control byte carrying 0xBC; payload bytes never count.
    function automatic logic is_com(input logic [7:0] data, input logic valid);
        return (!valid) && (data == COM_CHAR);
    endfunction

endpackage

// File: rtl/phy_rx_link_ctrl_if.sv
// Lane byte inputs, software enable and link status outputs of the receive link controller.
interface phy_rx_link_ctrl_if;

    logic       link_en;
    logic [7:0] data_par_0;
    logic [7:0] data_par_1;
    logic       valid_par_0;
    logic       valid_par_1;
    logic       lane_lock_0;
    logic       lane_lock_1;
    logic       link_up;
    logic       unstrip_en;
    logic [3:0] align_fail;

    modport master (
        output link_en, data_par_0, data_par_1, valid_par_0, valid_par_1,
        input  lane_lock_0, lane_lock_1, link_up, unstrip_en, align_fail
    );

    modport slave (
        input  link_en, data_par_0, data_par_1, valid_par_0, valid_par_1,
        output lane_lock_0, lane_lock_1, link_up, unstrip_en, align_fail
    );

endinterface

// File: rtl/phy_rx_link_ctrl_lane_sync.sv
// Per-lane symbol lock: acquires lock on a run of commas and drops it after a run of bad bytes.
module phy_rx_lane_sync
    import phy_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic       clk_f,
    input  logic       reset_L,
    input  logic [7:0] data_par,
    input  logic       valid_par,
    output logic       lane_lock
);

    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W = $clog2(LOSS_CNT + 1);

    lane_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BAD_W-1:0] bad_q;
    logic             lock_q;

    logic             isCom;
    logic             isBad;
    logic [CNT_W-1:0] cntInc;
    logic [BAD_W-1:0] badInc;

    assign isCom  = is_com(data_par, valid_par);
    assign isBad  = (!valid_par) && (data_par != COM_CHAR);
    assign cntInc = cnt_q + 1'b1;
    assign badInc = bad_q + 1'b1;

    always_ff @(posedge clk_f) begin
        if (!reset_L) begin
            state_q <= SEARCH;
            cnt_q   <= '0;
            bad_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (isCom) begin
                        cnt_q <= CNT_W'(1);
                        if (LOCK_CNT == 1) begin
                            state_q <= LOCKED;
                            lock_q  <= 1'b1;
                        end else begin
                            state_q <= ACQUIRE;
                        end
                    end
                end
                ACQUIRE: begin
                    if (isCom) begin
                        cnt_q <= cntInc;
                        if (cntInc == CNT_W'(LOCK_CNT)) begin
                            state_q <= LOCKED;
                            lock_q  <= 1'b1;
                            bad_q   <= '0;
                        end
                    end else begin
                        state_q <= SEARCH;
                        cnt_q   <= '0;
                    end
                end
                LOCKED: begin
                    // Payload and commas both prove the lane is still framed correctly.
                    if (isBad) begin
                        if (badInc == BAD_W'(LOSS_CNT)) begin
                            state_q <= SEARCH;
                            lock_q  <= 1'b0;
                            bad_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            bad_q <= badInc;
                        end
                    end else begin
                        bad_q <= '0;
                    end
                end
                default: begin
                    state_q <= SEARCH;
                    cnt_q   <= '0;
                    bad_q   <= '0;
                    lock_q  <= 1'b0;
                end
            endcase
        end
    end

    assign lane_lock = lock_q;

endmodule

// File: rtl/phy_rx_link_ctrl.sv
// Two-lane receive link controller: brings the link up once both lanes are locked
// and see a common comma, and enables the byte-unstripping path while up.
module phy_rx_link_ctrl
    import phy_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ALIGN_TO = 16
) (
    input  logic               clk_f,
    input  logic               reset_L,
    phy_rx_link_ctrl_if.slave  bus
);

    localparam int TMR_W = $clog2(ALIGN_TO);

    link_state_e      state_q;
    logic [TMR_W-1:0] tmr_q;
    logic [3:0]       alignFail_q;
    logic             linkUp_q;
    logic             unstripEn_q;

    logic             lock0;
    logic             lock1;
    logic             comBoth;
    logic             keepLink;

    phy_rx_lane_sync #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) u_lane0 (
        .clk_f     (clk_f),
        .reset_L   (reset_L),
        .data_par  (bus.data_par_0),
        .valid_par (bus.valid_par_0),
        .lane_lock (lock0)
    );

    phy_rx_lane_sync #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) u_lane1 (
        .clk_f     (clk_f),
        .reset_L   (reset_L),
        .data_par  (bus.data_par_1),
        .valid_par (bus.valid_par_1),
        .lane_lock (lock1)
    );

    assign comBoth  = is_com(bus.data_par_0, bus.valid_par_0) && is_com(bus.data_par_1, bus.valid_par_1);
    assign keepLink = bus.link_en && lock0 && lock1;

    // Losing keepLink is checked first so it wins over both alignment and timeout.
    always_ff @(posedge clk_f) begin
        if (!reset_L) begin
            state_q     <= DOWN;
            tmr_q       <= '0;
            alignFail_q <= '0;
            linkUp_q    <= 1'b0;
            unstripEn_q <= 1'b0;
        end else begin
            case (state_q)
                DOWN: begin
                    if (keepLink) begin
                        state_q <= ALIGN;
                        tmr_q   <= '0;
                    end
                end
                ALIGN: begin
                    if (!keepLink) begin
                        state_q <= DOWN;
                    end else if (comBoth) begin
                        state_q     <= UP;
                        linkUp_q    <= 1'b1;
                        unstripEn_q <= 1'b1;
                    end else if (tmr_q == TMR_W'(ALIGN_TO - 1)) begin
                        state_q <= DOWN;
                        if (alignFail_q != 4'hF) begin
                            alignFail_q <= alignFail_q + 4'd1;
                        end
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                UP: begin
                    if (!keepLink) begin
                        state_q     <= DOWN;
                        linkUp_q    <= 1'b0;
                        unstripEn_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= DOWN;
                    linkUp_q    <= 1'b0;
                    unstripEn_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lane_lock_0 = lock0;
    assign bus.lane_lock_1 = lock1;
    assign bus.link_up     = linkUp_q;
    assign bus.unstrip_en  = unstripEn_q;
    assign bus.align_fail  = alignFail_q;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Directed and randomized bench for phy_rx_link_ctrl against a run-length based link model.
module tb_phy_rx_link_ctrl;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int ALIGN_TO = 16;
    localparam int C_COM    = 0;
    localparam int C_DATA   = 1;
    localparam int C_BAD    = 2;

    logic clk_f   = 1'b0;
    logic reset_L = 1'b0;

    phy_rx_link_ctrl_if bus ();

    phy_rx_link_ctrl #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .ALIGN_TO (ALIGN_TO)
    ) dut (
        .clk_f   (clk_f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk_f = ~clk_f;

    int total = 0;
    int bad   = 0;

    // Model: lock is derived from run lengths of commas and bad bytes.
    int comRun[2];
    int badRun[2];
    bit mLock[2];
    bit mUp;
    bit mAligning;
    int alignAge;
    int fails;

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            comRun[i] = 0;
            badRun[i] = 0;
            mLock[i]  = 1'b0;
        end
        mUp       = 1'b0;
        mAligning = 1'b0;
        alignAge  = 0;
        fails     = 0;
    endtask

    task automatic modelStep(input logic rst, input logic en, input logic [7:0] d0, input logic v0,
                             input logic [7:0] d1, input logic v1);
        bit com[2];
        bit isBad[2];
        bit bothLocked;
        if (!rst) begin
            modelReset();
            return;
        end
        com[0]     = !v0 && (d0 == 8'hBC);
        com[1]     = !v1 && (d1 == 8'hBC);
        isBad[0]   = !v0 && (d0 != 8'hBC);
        isBad[1]   = !v1 && (d1 != 8'hBC);
        bothLocked = mLock[0] && mLock[1];

        if (!mUp && !mAligning) begin
            if (en && bothLocked) begin
                mAligning = 1'b1;
                alignAge  = 0;
            end
        end else if (!en || !bothLocked) begin
            mUp       = 1'b0;
            mAligning = 1'b0;
        end else if (mAligning) begin
            if (com[0] && com[1]) begin
                mAligning = 1'b0;
                mUp       = 1'b1;
            end else if (alignAge == ALIGN_TO - 1) begin
                mAligning = 1'b0;
                if (fails < 15) fails++;
            end else begin
                alignAge++;
            end
        end

        for (int i = 0; i < 2; i++) begin
            if (!mLock[i]) begin
                if (com[i]) begin
                    comRun[i]++;
                    if (comRun[i] == LOCK_CNT) begin
                        mLock[i]  = 1'b1;
                        badRun[i] = 0;
                    end
                end else begin
                    comRun[i] = 0;
                end
            end else if (isBad[i]) begin
                badRun[i]++;
                if (badRun[i] == LOSS_CNT) begin
                    mLock[i]  = 1'b0;
                    badRun[i] = 0;
                    comRun[i] = 0;
                end
            end else begin
                badRun[i] = 0;
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("lane_lock_0", {3'b0, bus.lane_lock_0}, {3'b0, mLock[0]});
        checkValue("lane_lock_1", {3'b0, bus.lane_lock_1}, {3'b0, mLock[1]});
        checkValue("link_up",     {3'b0, bus.link_up},     {3'b0, mUp});
        checkValue("unstrip_en",  {3'b0, bus.unstrip_en},  {3'b0, mUp});
        checkValue("align_fail",  bus.align_fail,          4'(fails));
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] d0, input logic v0,
                                 input logic [7:0] d1, input logic v1);
        reset_L         = rst;
        bus.link_en     = en;
        bus.data_par_0  = d0;
        bus.valid_par_0 = v0;
        bus.data_par_1  = d1;
        bus.valid_par_1 = v1;
        @(posedge clk_f);
        modelStep(rst, en, d0, v0, d1, v1);
        #1;
        checkOutput();
    endtask

    task automatic makeByte(input int cls, output logic [7:0] d, output logic v);
        d = 8'($urandom_range(0, 255));
        v = 1'b0;
        if (cls == C_COM) begin
            d = 8'hBC;
        end else if (cls == C_DATA) begin
            v = 1'b1;
        end else if (d == 8'hBC) begin
            d = 8'h3C;
        end
    endtask

    task automatic step(input logic en, input int c0, input int c1);
        logic [7:0] d0;
        logic [7:0] d1;
        logic       v0;
        logic       v1;
        makeByte(c0, d0, v0);
        makeByte(c1, d1, v1);
        applyStimulus(1'b1, en, d0, v0, d1, v1);
    endtask

    task automatic pulseReset();
        applyStimulus(1'b0, 1'b1, 8'hBC, 1'b0, 8'hBC, 1'b0);
    endtask

    int  badPct;
    int  r0;
    int  r1;
    int  c0;
    int  c1;

    initial begin
        modelReset();
        bus.link_en     = 1'b0;
        bus.data_par_0  = 8'h00;
        bus.valid_par_0 = 1'b0;
        bus.data_par_1  = 8'h00;
        bus.valid_par_1 = 1'b0;

        $display("[TB] reset and basic bring-up");
        pulseReset();
        pulseReset();
        checkValue("reset_link_up", {3'b0, bus.link_up}, 4'd0);
        repeat (4) step(1'b1, C_COM, C_COM);
        checkValue("lock0_after_4com", {3'b0, bus.lane_lock_0}, 4'd1);
        checkValue("lock1_after_4com", {3'b0, bus.lane_lock_1}, 4'd1);
        step(1'b1, C_COM, C_COM);
        checkValue("up_not_yet", {3'b0, bus.link_up}, 4'd0);
        step(1'b1, C_COM, C_COM);
        checkValue("up_after_2", {3'b0, bus.link_up}, 4'd1);

        $display("[TB] interrupted comma run");
        pulseReset();
        repeat (2) step(1'b1, C_COM, C_BAD);
        checkValue("no_lock_2com", {3'b0, bus.lane_lock_0}, 4'd0);
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 8'h00, 1'b0);
        repeat (3) step(1'b1, C_COM, C_BAD);
        checkValue("no_lock_3com", {3'b0, bus.lane_lock_0}, 4'd0);
        step(1'b1, C_COM, C_BAD);
        checkValue("lock_final_run", {3'b0, bus.lane_lock_0}, 4'd1);

        $display("[TB] bad bytes while up");
        repeat (6) step(1'b1, C_COM, C_COM);
        checkValue("up_before_bad", {3'b0, bus.link_up}, 4'd1);
        repeat (2) applyStimulus(1'b1, 1'b1, 8'hBC, 1'b0, 8'h00, 1'b0);
        step(1'b1, C_COM, C_COM);
        repeat (2) applyStimulus(1'b1, 1'b1, 8'hBC, 1'b0, 8'h00, 1'b0);
        checkValue("bad_cleared", {3'b0, bus.lane_lock_1}, 4'd1);
        applyStimulus(1'b1, 1'b1, 8'hBC, 1'b0, 8'h00, 1'b0);
        checkValue("lock1_dropped", {3'b0, bus.lane_lock_1}, 4'd0);
        checkValue("up_lingers", {3'b0, bus.link_up}, 4'd1);
        step(1'b1, C_COM, C_COM);
        checkValue("up_dropped", {3'b0, bus.link_up}, 4'd0);

        $display("[TB] alignment timeouts");
        pulseReset();
        repeat (4) step(1'b1, C_COM, C_COM);
        for (int k = 1; k <= 17 * 17; k++) begin
            step(1'b1, C_COM, C_DATA);
            if (k == 17) checkValue("fail_one", bus.align_fail, 4'd1);
        end
        checkValue("fail_saturated", bus.align_fail, 4'd15);

        $display("[TB] software disable");
        repeat (3) step(1'b1, C_COM, C_COM);
        checkValue("up_before_dis", {3'b0, bus.link_up}, 4'd1);
        step(1'b0, C_COM, C_COM);
        checkValue("dis_up", {3'b0, bus.link_up}, 4'd0);
        checkValue("dis_unstrip", {3'b0, bus.unstrip_en}, 4'd0);
        checkValue("dis_lock0", {3'b0, bus.lane_lock_0}, 4'd1);
        step(1'b1, C_COM, C_COM);
        checkValue("reenable_align", {3'b0, bus.link_up}, 4'd0);
        step(1'b1, C_COM, C_COM);
        checkValue("reenable_up", {3'b0, bus.link_up}, 4'd1);

        $display("[TB] reset while up");
        pulseReset();
        checkValue("rst_up", {3'b0, bus.link_up}, 4'd0);
        checkValue("rst_fail", bus.align_fail, 4'd0);
        repeat (3) step(1'b1, C_COM, C_COM);
        checkValue("rst_reacq", {3'b0, bus.lane_lock_0}, 4'd0);
        repeat (3) step(1'b1, C_COM, C_COM);
        checkValue("rst_up_again", {3'b0, bus.link_up}, 4'd1);

        $display("[TB] random soak");
        for (int blk = 0; blk < 12; blk++) begin
            badPct = $urandom_range(2, 40);
            for (int i = 0; i < 50; i++) begin
                r0 = $urandom_range(0, 99);
                r1 = $urandom_range(0, 99);
                c0 = (r0 < badPct) ? C_BAD : ((r0 < badPct + 15) ? C_DATA : C_COM);
                c1 = (r1 < badPct) ? C_BAD : ((r1 < badPct + 15) ? C_DATA : C_COM);
                if ($urandom_range(0, 299) == 0) begin
                    pulseReset();
                end else begin
                    step(($urandom_range(0, 24) != 0), c0, c1);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
